jtpang_sdram_bank_model: RTL and testbench

- Memory-side responder for the four-bank SDRAM read interface (baN_addr / ba_rd / ba_ack / ba_dst / ba_dok / ba_rdy / data_read) and for the download write port (prog_*).
- Backed by an internal synchronous 16-bit word array.
- Serves game-side bank requests with round-robin arbitration, a fixed access latency and fixed-length bursts.
- Used as the SDRAM stand-in for simulation and for BRAM-only builds.

---
 rtl/jtpang_sdram_bank_model.sv | 201 ++++++++++++++++++++
 tb/tb_jtpang_sdram_bank_model.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtpang_sdram_bank_model.sv
// SDRAM stand-in: four read banks served round-robin from an internal 16-bit
// word array, with a fixed ack-to-data latency and fixed-length bursts, plus
// a byte-masked download write port.
module jtpang_sdram_bank_model #(
    parameter int BAW   = 12,
    parameter int LAT   = 2,
    parameter int BURST = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] ba0_addr,
    input  logic [21:0] ba1_addr,
    input  logic [21:0] ba2_addr,
    input  logic [21:0] ba3_addr,
    input  logic [3:0]  ba_rd,
    output logic [3:0]  ba_ack,
    output logic [3:0]  ba_dst,
    output logic [3:0]  ba_dok,
    output logic [3:0]  ba_rdy,
    output logic [15:0] data_read,
    input  logic        downloading,
    input  logic [21:0] prog_addr,
    input  logic [1:0]  prog_ba,
    input  logic [15:0] prog_data,
    input  logic [1:0]  prog_mask,
    input  logic        prog_we,
    output logic        prog_ack,
    output logic        prog_rdy
);
    localparam int AW = BAW + 2;
    localparam int CW = 3;

    typedef enum logic [2:0] {IDLE, PWR, PRDY, ACK, WAIT, DATA} state_t;

    logic [15:0] mem [0:(1<<AW)-1];

    state_t          state_q, state_d;
    logic [1:0]      bank_q, bank_d;
    logic [BAW-1:0]  addr_q, addr_d;
    logic [1:0]      last_q, last_d;
    logic            mask_q, mask_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      wcnt_q, wcnt_d;
    logic [3:0]      ba_ack_q, ba_ack_d, ba_dst_q, ba_dst_d;
    logic [3:0]      ba_dok_q, ba_dok_d, ba_rdy_q, ba_rdy_d;
    logic            prog_ack_q, prog_ack_d, prog_rdy_q, prog_rdy_d;
    logic [15:0]     data_read_q;

    logic [BAW-1:0]  req_addr [4];
    logic [1:0]      cand, grant_b;
    logic            grant_vld, load_word, first_word, rd_en, wr_en;
    logic [AW-1:0]   rd_idx, wr_idx;
    logic            unused_bits;

    assign req_addr[0] = ba0_addr[BAW-1:0];
    assign req_addr[1] = ba1_addr[BAW-1:0];
    assign req_addr[2] = ba2_addr[BAW-1:0];
    assign req_addr[3] = ba3_addr[BAW-1:0];
    assign unused_bits = ^{ba0_addr, ba1_addr, ba2_addr, ba3_addr, prog_addr};

    assign wr_idx = {prog_ba, prog_addr[BAW-1:0]};
    assign wr_en  = (state_q == IDLE) && prog_we && !rst;

    // Round-robin search starting after the last granted bank; the bank that
    // just finished is skipped for one IDLE cycle to absorb a late ba_rd drop.
    always_comb begin
        grant_vld = 1'b0;
        grant_b   = last_q;
        cand      = last_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!grant_vld && ba_rd[cand] && !(mask_q && cand == bank_q)) begin
                grant_vld = 1'b1;
                grant_b   = cand;
            end
        end
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        addr_d     = addr_q;
        last_d     = last_q;
        mask_d     = 1'b0;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        ba_ack_d   = '0;
        ba_dst_d   = '0;
        ba_dok_d   = '0;
        ba_rdy_d   = '0;
        prog_ack_d = 1'b0;
        prog_rdy_d = 1'b0;
        load_word  = 1'b0;
        first_word = (state_q != DATA);
        rd_en      = 1'b0;
        rd_idx     = {bank_q, addr_q};
        case (state_q)
            IDLE: begin
                if (prog_we) begin
                    state_d    = PWR;
                    prog_ack_d = 1'b1;
                end else if (!downloading && grant_vld) begin
                    state_d           = ACK;
                    ba_ack_d[grant_b] = 1'b1;
                    bank_d            = grant_b;
                    addr_d            = req_addr[grant_b];
                    last_d            = grant_b;
                end
            end
            PWR: begin
                state_d    = PRDY;
                prog_rdy_d = 1'b1;
            end
            PRDY: state_d = IDLE;
            ACK: begin
                if (LAT == 1) begin
                    load_word = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CW'(LAT - 2);
                end
            end
            WAIT: begin
                if (cnt_q == '0) load_word = 1'b1;
                else             cnt_d     = cnt_q - 1'b1;
            end
            DATA: begin
                if (wcnt_q == 2'(BURST - 1)) begin
                    state_d = IDLE;
                    mask_d  = 1'b1;
                end else begin
                    load_word = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Each word fetch advances the address, wrapping inside the bank.
        if (load_word) begin
            state_d          = DATA;
            rd_en            = 1'b1;
            addr_d           = addr_q + 1'b1;
            wcnt_d           = first_word ? 2'd0 : wcnt_q + 2'd1;
            ba_dok_d[bank_q] = 1'b1;
            ba_dst_d[bank_q] = first_word;
            ba_rdy_d[bank_q] = (wcnt_d == 2'(BURST - 1));
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bank_q     <= 2'd0;
            addr_q     <= '0;
            last_q     <= 2'd3;
            mask_q     <= 1'b0;
            cnt_q      <= '0;
            wcnt_q     <= 2'd0;
            ba_ack_q   <= '0;
            ba_dst_q   <= '0;
            ba_dok_q   <= '0;
            ba_rdy_q   <= '0;
            prog_ack_q <= 1'b0;
            prog_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            ba_ack_q   <= ba_ack_d;
            ba_dst_q   <= ba_dst_d;
            ba_dok_q   <= ba_dok_d;
            ba_rdy_q   <= ba_rdy_d;
            prog_ack_q <= prog_ack_d;
            prog_rdy_q <= prog_rdy_d;
        end
    end

    // Word array: byte-masked writes, registered read port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!prog_mask[0]) mem[wr_idx][7:0]  <= prog_data[7:0];
            if (!prog_mask[1]) mem[wr_idx][15:8] <= prog_data[15:8];
        end
        if (rst)        data_read_q <= '0;
        else if (rd_en) data_read_q <= mem[rd_idx];
    end

    assign ba_ack    = ba_ack_q;
    assign ba_dst    = ba_dst_q;
    assign ba_dok    = ba_dok_q;
    assign ba_rdy    = ba_rdy_q;
    assign prog_ack  = prog_ack_q;
    assign prog_rdy  = prog_rdy_q;
    assign data_read = data_read_q;

endmodule

// File: tb/tb_jtpang_sdram_bank_model.sv
// Bench for jtpang_sdram_bank_model: directed stimulus pushes expected output
// events (with absolute cycle numbers) into a queue; a negedge monitor pops
// and compares whenever any handshake output is active.
module tb_jtpang_sdram_bank_model;
    localparam int LAT   = 2;
    localparam int BURST = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [21:0] ba0_addr = '0, ba1_addr = '0, ba2_addr = '0, ba3_addr = '0;
    logic [3:0]  ba_rd = '0;
    logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
    logic [15:0] data_read;
    logic        downloading = 1'b0;
    logic [21:0] prog_addr = '0;
    logic [1:0]  prog_ba = '0;
    logic [15:0] prog_data = '0;
    logic [1:0]  prog_mask = '0;
    logic        prog_we = 1'b0;
    logic        prog_ack, prog_rdy;

    jtpang_sdram_bank_model #(.BAW(12), .LAT(LAT), .BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
        .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
        .data_read(data_read), .downloading(downloading),
        .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_data(prog_data),
        .prog_mask(prog_mask), .prog_we(prog_we),
        .prog_ack(prog_ack), .prog_rdy(prog_rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  ack, dst, dok, rdy;
        logic        pa, pr, chk;
        logic [15:0] d;
    } exp_t;

    exp_t q[$];
    exp_t e;

    task automatic push(input int c, input logic [3:0] ack, input logic [3:0] dst,
                        input logic [3:0] dok, input logic [3:0] rdy,
                        input logic pa, input logic pr, input logic chkd,
                        input logic [15:0] d);
        exp_t x;
        x.cyc = c; x.ack = ack; x.dst = dst; x.dok = dok; x.rdy = rdy;
        x.pa = pa; x.pr = pr; x.chk = chkd; x.d = d;
        q.push_back(x);
    endtask

    // Grant decided at cycle t: ack at t+1, word k at t+1+LAT+k.
    task automatic push_burst(input int b, input int t, input logic [15:0] w0, input logic [15:0] w1);
        logic [3:0] m;
        m = 4'b0001 << b;
        push(t + 1, m, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 0; k < BURST; k++)
            push(t + 1 + LAT + k, 4'b0, (k == 0) ? m : 4'b0, m,
                 (k == BURST - 1) ? m : 4'b0, 1'b0, 1'b0, 1'b1, (k == 0) ? w0 : w1);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int b, input logic [21:0] a);
        case (b)
            0: ba0_addr = a;
            1: ba1_addr = a;
            2: ba2_addr = a;
            default: ba3_addr = a;
        endcase
    endtask

    task automatic wr(input logic [1:0] b, input logic [11:0] a, input logic [15:0] d, input logic [1:0] m);
        prog_ba = b; prog_addr = {10'd0, a}; prog_data = d; prog_mask = m; prog_we = 1'b1;
        push(cyc + 1, 4'b0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        push(cyc + 2, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        tick();
        prog_we = 1'b0;
        tick();
        tick();
    endtask

    // Single-bank read; the request address is scrambled after the ack.
    task automatic rd1(input int b, input logic [21:0] a, input logic [15:0] w0, input logic [15:0] w1);
        int c;
        set_addr(b, a);
        ba_rd = 4'b0001 << b;
        c = cyc;
        push_burst(b, c, w0, w1);
        tick();
        tick();
        set_addr(b, 22'h3ABC);
        repeat (3) tick();
        ba_rd = 4'b0;
        tick();
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (|{ba_ack, ba_dst, ba_dok, ba_rdy, prog_ack, prog_rdy}) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out cyc=%0d ack=%b dst=%b dok=%b rdy=%b pack=%b prdy=%b",
                         cyc, ba_ack, ba_dst, ba_dok, ba_rdy, prog_ack, prog_rdy);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || ba_ack !== e.ack || ba_dst !== e.dst || ba_dok !== e.dok ||
                    ba_rdy !== e.rdy || prog_ack !== e.pa || prog_rdy !== e.pr ||
                    (e.chk && data_read !== e.d)) begin
                    bad++;
                    $display("FAIL out_event got cyc=%0d ack=%b dst=%b dok=%b rdy=%b pa=%b pr=%b d=%h; expected cyc=%0d ack=%b dst=%b dok=%b rdy=%b pa=%b pr=%b d=%h",
                             cyc, ba_ack, ba_dst, ba_dok, ba_rdy, prog_ack, prog_rdy, data_read,
                             e.cyc, e.ack, e.dst, e.dok, e.rdy, e.pa, e.pr, e.d);
                end
            end
        end
    end

    initial begin
        int c;
        repeat (3) tick();
        chk("rst_ack", 32'(ba_ack), 32'h0);
        chk("rst_dst_dok_rdy", 32'({ba_dst, ba_dok, ba_rdy}), 32'h0);
        chk("rst_prog", 32'({prog_ack, prog_rdy}), 32'h0);
        chk("rst_data", 32'(data_read), 32'h0);
        rst = 1'b0;

        // Preload memory through the download port.
        wr(2'd1, 12'h010, 16'h1234, 2'b00);
        wr(2'd1, 12'h011, 16'hABCD, 2'b00);
        wr(2'd0, 12'h020, 16'h2000, 2'b00);
        wr(2'd0, 12'h021, 16'h2001, 2'b00);
        wr(2'd1, 12'h020, 16'h2010, 2'b00);
        wr(2'd1, 12'h021, 16'h2011, 2'b00);
        wr(2'd2, 12'h020, 16'h2020, 2'b00);
        wr(2'd2, 12'h021, 16'h2021, 2'b00);
        wr(2'd3, 12'h020, 16'h2030, 2'b00);
        wr(2'd3, 12'h021, 16'h2031, 2'b00);
        wr(2'd0, 12'hFFF, 16'hF00D, 2'b00);
        wr(2'd0, 12'h000, 16'h0BAD, 2'b00);
        wr(2'd0, 12'h001, 16'h0001, 2'b00);
        wr(2'd2, 12'h040, 16'h1111, 2'b00);
        wr(2'd2, 12'h041, 16'h7777, 2'b00);
        wr(2'd2, 12'h040, 16'h5A5A, 2'b01);

        // All banks requesting: grants 0,1,2,3,0 five cycles apart.
        ba0_addr = 22'h020; ba1_addr = 22'h020; ba2_addr = 22'h020; ba3_addr = 22'h020;
        ba_rd = 4'hF;
        c = cyc;
        push_burst(0, c,      16'h2000, 16'h2001);
        push_burst(1, c + 5,  16'h2010, 16'h2011);
        push_burst(2, c + 10, 16'h2020, 16'h2021);
        push_burst(3, c + 15, 16'h2030, 16'h2031);
        push_burst(0, c + 20, 16'h2000, 16'h2001);
        repeat (22) tick();
        ba_rd = 4'b0;
        repeat (4) tick();

        // Basic bank-1 read, in-bank address wrap, masked write read-back.
        rd1(1, 22'h010, 16'h1234, 16'hABCD);
        rd1(0, 22'hFFF, 16'hF00D, 16'h0BAD);
        rd1(2, 22'h040, 16'h5A11, 16'h7777);

        // Write and read request together: write first, ack four cycles later.
        c = cyc;
        prog_ba = 2'd3; prog_addr = 22'h100; prog_data = 16'hCAFE; prog_mask = 2'b00;
        prog_we = 1'b1; ba0_addr = 22'h000; ba_rd = 4'b0001;
        push(c + 1, 4'b0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        push(c + 2, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        push_burst(0, c + 3, 16'h0BAD, 16'h0001);
        tick();
        prog_we = 1'b0;
        repeat (7) tick();
        ba_rd = 4'b0;
        tick();

        // Downloading blocks grants; release lets the pending request through.
        downloading = 1'b1;
        ba_rd = 4'b0001;
        repeat (20) begin
            tick();
            chk("dl_no_ack", 32'(ba_ack), 32'h0);
        end
        downloading = 1'b0;
        push_burst(0, cyc, 16'h0BAD, 16'h0001);
        repeat (5) tick();
        ba_rd = 4'b0;
        tick();

        // Reset during WAIT: no data phase, bank 0 wins afterwards.
        c = cyc;
        ba1_addr = 22'h010; ba0_addr = 22'h000;
        ba_rd = 4'b0010;
        push(c + 1, 4'b0010, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick();
        tick();
        rst = 1'b1;
        ba_rd = 4'b0011;
        tick();
        chk("midrst_ack", 32'(ba_ack), 32'h0);
        chk("midrst_dst_dok_rdy", 32'({ba_dst, ba_dok, ba_rdy}), 32'h0);
        chk("midrst_data", 32'(data_read), 32'h0);
        rst = 1'b0;
        push_burst(0, cyc, 16'h0BAD, 16'h0001);
        tick();
        tick();
        ba_rd = 4'b0;
        repeat (10) tick();

        chk("pending_events", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
